// File: rtl/booth_mul_seq.sv
//------------------------------------------------------------------------------
// booth_mul_seq : sequential radix-4 Booth signed multiplier, one bit-pair/clk.
// Optional macro BOOTH_EARLY_TERM_EN: finish early once remaining steps are +0.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module booth_mul_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] q_in,
  input  logic [WIDTH-1:0] m_in,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int              STEPS   = WIDTH / 2;
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(STEPS - 1);
  localparam logic [0:0]      ST_IDLE = 1'b0;
  localparam logic [0:0]      ST_RUN  = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d;

  logic [WIDTH+1:0]   upper_ext, q_ext, q2_ext, addend, sum;
  logic [2*WIDTH-1:0] step_acc;
  logic               finish;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start)  state_d = ST_RUN;
      ST_RUN:  if (finish) state_d = ST_IDLE;
      default:             state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ready = (state_q == ST_IDLE);
    busy  = (state_q != ST_IDLE);
  end

  // One Booth step: recode {acc[1:0], carry}, add into the sign-extended upper half.
  always_comb begin
    upper_ext = {{2{acc_q[2*WIDTH-1]}}, acc_q[2*WIDTH-1:WIDTH]};
    q_ext     = {{2{q_q[WIDTH-1]}}, q_q};
    q2_ext    = {q_q[WIDTH-1], q_q, 1'b0};
    case ({acc_q[1:0], carry_q})
      3'b001, 3'b010: addend = q_ext;
      3'b011:         addend = q2_ext;
      3'b100:         addend = -q2_ext;
      3'b101, 3'b110: addend = -q_ext;
      default:        addend = '0;
    endcase
    sum      = upper_ext + addend;
    step_acc = {sum, acc_q[WIDTH-1:2]};
  end

`ifdef BOOTH_EARLY_TERM_EN
  logic [WIDTH-1:0]   rem_mask, rem_bits;
  logic [CNT_W+1:0]   shamt;
  logic               early;
  logic [2*WIDTH-1:0] early_acc;

  // Remaining multiplier bits sit at acc[WIDTH-1-2*count:0]; uniform bits plus matching carry recode to +0.
  always_comb begin
    rem_mask  = {WIDTH{1'b1}} >> (2 * cnt_q);
    rem_bits  = acc_q[WIDTH-1:0] & rem_mask;
    early     = ((rem_bits == '0) && !carry_q) || ((rem_bits == rem_mask) && carry_q);
    shamt     = (CNT_W+2)'(WIDTH) - {1'b0, cnt_q, 1'b0};
    early_acc = $signed(acc_q) >>> shamt;
  end
`else
  logic early;
  logic [2*WIDTH-1:0] early_acc;

  always_comb begin
    early     = 1'b0;
    early_acc = '0;
  end
`endif

  always_comb begin
    q_d     = q_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    finish  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          q_d     = q_in;
          acc_d   = {{WIDTH{1'b0}}, m_in};
          carry_d = 1'b0;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        if (early) begin
          acc_d  = early_acc;
          finish = 1'b1;
        end else begin
          acc_d   = step_acc;
          carry_d = acc_q[1];
          cnt_d   = cnt_q + 1'b1;
          finish  = (cnt_q == LAST);
        end
        if (finish) begin
          hi_d   = acc_d[2*WIDTH-1:WIDTH];
          lo_d   = acc_d[WIDTH-1:0];
          done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      q_q     <= q_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign done   = done_q;
  assign hi_out = hi_q;
  assign lo_out = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_booth_mul_seq.sv
//------------------------------------------------------------------------------
// tb_booth_mul_seq : directed vectors into a scoreboard queue, checked on done.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_booth_mul_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] q_in, m_in;
  logic        ready, busy, done;
  logic [31:0] hi_out, lo_out;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          at;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

`ifdef BOOTH_EARLY_TERM_EN
  localparam int LAT_STD = -1;
  localparam logic [31:0] M_LONG = 32'h5555_5555;
  localparam logic [31:0] LONG_LO = 32'hFFFF_FFFF;
`else
  localparam int LAT_STD = 16;
  localparam logic [31:0] M_LONG = 32'd7;
  localparam logic [31:0] LONG_LO = 32'd21;
`endif

  booth_mul_seq #(.WIDTH(32), .CNT_W(5)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .q_in   (q_in),
    .m_in   (m_in),
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .hi_out (hi_out),
    .lo_out (lo_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 expected no pulse (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("hi_out", {32'h0, hi_out}, {32'h0, e.hi});
        chk("lo_out", {32'h0, lo_out}, {32'h0, e.lo});
        chk("ready_in_done", {63'h0, ready}, 64'd1);
        chk("busy_in_done", {63'h0, busy}, 64'd0);
        if (e.at >= 0) chk("latency_cycle", 64'(cyc), 64'(e.at));
      end
    end
  end

  task automatic issue(input logic [31:0] q, input logic [31:0] m, input logic [31:0] ehi,
                       input logic [31:0] elo, input int lat, input bit push);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (ready !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: got ready=%b expected 1", ready);
    end
    q_in  = q;
    m_in  = m;
    start = 1'b1;
    if (push) begin
      e.hi = ehi;
      e.lo = elo;
      e.at = (lat < 0) ? -1 : cyc + 1 + lat;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    start = 1'b0;
    q_in  = '0;
    m_in  = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {63'h0, ready}, 64'd1);
    chk("rst_busy",  {63'h0, busy},  64'd0);
    chk("rst_done",  {63'h0, done},  64'd0);
    chk("rst_hilo",  {hi_out, lo_out}, 64'h0);
    rst_n = 1'b1;

    issue(32'd2,          32'd5,          32'h0000_0000, 32'h0000_000A, LAT_STD, 1'b1);
    issue(32'hFFFF_FFFE,  32'd5,          32'hFFFF_FFFF, 32'hFFFF_FFF6, LAT_STD, 1'b1);
    issue(32'h8000_0000,  32'h8000_0000,  32'h4000_0000, 32'h0000_0000, LAT_STD, 1'b1);
    issue(32'h7FFF_FFFF,  32'h8000_0000,  32'hC000_0000, 32'h8000_0000, LAT_STD, 1'b1);
    issue(32'd0,          32'hFFFF_FFFF,  32'h0000_0000, 32'h0000_0000, LAT_STD, 1'b1);

    // New operands and a start pulse mid-run must be ignored.
    issue(32'd3, M_LONG, 32'h0, LONG_LO, LAT_STD, 1'b1);
    repeat (4) @(negedge clk);
    q_in  = 32'd100;
    m_in  = 32'd100;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    // Reset mid-operation: abandoned, no done, outputs cleared at once.
    issue(32'd3, M_LONG, 32'h0, 32'h0, LAT_STD, 1'b0);
    repeat (8) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ready", {63'h0, ready}, 64'd1);
    chk("midrst_done",  {63'h0, done},  64'd0);
    chk("midrst_hilo",  {hi_out, lo_out}, 64'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, LAT_STD, 1'b1);

`ifdef BOOTH_EARLY_TERM_EN
    issue(32'd5, 32'd0,          32'h0, 32'h0,          1,  1'b1);
    issue(32'd9, 32'd1,          32'h0, 32'h9,          2,  1'b1);
    issue(32'd1, 32'h5555_5555,  32'h0, 32'h5555_5555,  16, 1'b1);
`endif

    n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending results expected 0", sb.size());
    end
    repeat (20) @(negedge clk);
    chk("final_hilo", {hi_out, lo_out}, 64'h0000_0000_0000_0001 |
`ifdef BOOTH_EARLY_TERM_EN
        64'h0000_0000_5555_5555
`else
        64'h0
`endif
    );
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
